gemm_loop_counter: RTL and testbench

//   Parametrised nested loop counter for GEMM tile sequencing (row/col/k style loops).

---
 rtl/gemm_loop_counter.sv | 128 ++++++++++++
 tb/tb_gemm_loop_counter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/gemm_loop_counter.sv
// Nested loop counter for GEMM tile sequencing. Level 0 is the innermost loop.
// Each level has a runtime bound latched at start; levels carry upward on wrap.
module gemm_loop_counter #(
    parameter int NUM_LEVELS = 3,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_i,
    input  logic                             en_i,
    input  logic                             abort_i,
    input  logic                             mode_i,
    input  logic [NUM_LEVELS*CNT_WIDTH-1:0]  bound_i,
    output logic [NUM_LEVELS*CNT_WIDTH-1:0]  cnt_o,
    output logic [NUM_LEVELS-1:0]            wrap_o,
    output logic                             last_o,
    output logic                             done_o,
    output logic                             busy_o,
    output logic [1:0]                       dbg_state
);

    // Handshake: inputs are sampled on every rising edge; start_i is accepted only
    // in IDLE/DONE, en_i/abort_i only in RUN, and abort_i wins over en_i.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    state_t                          state;
    state_t                          state_next;
    logic [NUM_LEVELS*CNT_WIDTH-1:0] cnt_q;
    logic [NUM_LEVELS*CNT_WIDTH-1:0] bound_q;
    logic                            mode_q;
    logic                            done_q;
    logic                            step;
    logic                            load;
    logic [NUM_LEVELS-1:0]           carry;
    logic [NUM_LEVELS-1:0]           at_bound;
    logic [NUM_LEVELS-1:0]           wrap;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) state_next = RUN;
            end
            RUN: begin
                if (abort_i) begin
                    state_next = IDLE;
                end else if (wrap[NUM_LEVELS-1]) begin
                    state_next = mode_q ? RUN : DONE;
                end
            end
            DONE: begin
                state_next = start_i ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy_o = (state == RUN);
        step   = (state == RUN) && en_i && !abort_i;
        load   = (state != RUN) && start_i;
    end

    // Carry chain: level k steps when all lower levels are at bound and stepping.
    always_comb begin
        logic acc;
        acc      = step;
        carry    = '0;
        at_bound = '0;
        wrap     = '0;
        for (int k = 0; k < NUM_LEVELS; k++) begin
            at_bound[k] = (cnt_q[k*CNT_WIDTH +: CNT_WIDTH] == bound_q[k*CNT_WIDTH +: CNT_WIDTH]);
            carry[k]    = acc;
            acc         = acc && at_bound[k];
            wrap[k]     = acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            bound_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= wrap[NUM_LEVELS-1];
            if (load) begin
                cnt_q   <= '0;
                bound_q <= bound_i;
                mode_q  <= mode_i;
            end else if ((state == RUN) && (abort_i || wrap[NUM_LEVELS-1])) begin
                cnt_q <= '0;
            end else begin
                for (int k = 0; k < NUM_LEVELS; k++) begin
                    if (carry[k]) begin
                        cnt_q[k*CNT_WIDTH +: CNT_WIDTH] <= at_bound[k] ? '0
                            : cnt_q[k*CNT_WIDTH +: CNT_WIDTH] + ONE;
                    end
                end
            end
        end
    end

    assign cnt_o     = cnt_q;
    assign wrap_o    = wrap;
    assign last_o    = wrap[NUM_LEVELS-1];
    assign done_o    = done_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_gemm_loop_counter.sv
// Bench for gemm_loop_counter: a driver pushes one expected observation per cycle,
// computed from a mixed-radix step model; a negedge monitor pops and compares.
module tb_gemm_loop_counter;

  localparam int NL = 3;
  localparam int W  = 4;
  localparam int OW = 2 + 1 + 1 + NL + NL*W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_i = 1'b0;
  logic            en_i = 1'b0;
  logic            abort_i = 1'b0;
  logic            mode_i = 1'b0;
  logic [NL*W-1:0] bound_i = '0;
  logic [NL*W-1:0] cnt_o;
  logic [NL-1:0]   wrap_o;
  logic            last_o;
  logic            done_o;
  logic            busy_o;
  logic [1:0]      dbg_state;

  always #5 clk = ~clk;

  gemm_loop_counter #(.NUM_LEVELS(NL), .CNT_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .en_i      (en_i),
    .abort_i   (abort_i),
    .mode_i    (mode_i),
    .bound_i   (bound_i),
    .cnt_o     (cnt_o),
    .wrap_o    (wrap_o),
    .last_o    (last_o),
    .done_o    (done_o),
    .busy_o    (busy_o),
    .dbg_state (dbg_state)
  );

  // scoreboard
  logic [OW-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  string phase = "init";

  // reference model: state 0 idle / 1 run / 2 done, n = enabled steps in pass
  int ms = 0;
  int n = 0;
  bit pend_done = 1'b0;
  bit m_mode = 1'b0;
  int b[NL];
  logic [NL*W-1:0] bnd_next = '0;
  logic mode_next = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s [%s] got=%h expected=%h", name, phase, got, exp);
  endtask

  task automatic model_reset();
    ms = 0;
    n = 0;
    pend_done = 1'b0;
    m_mode = 1'b0;
    for (int k = 0; k < NL; k++) b[k] = 0;
  endtask

  // drive one cycle of inputs and push the expected observation for it
  task automatic cycle(input bit en, input bit ab, input bit st);
    logic [NL-1:0]   w;
    logic [NL*W-1:0] c;
    logic [W-1:0]    digit;
    logic [1:0]      ms2;
    int r;
    int prod;
    bit stp;
    @(posedge clk);
    #1;
    en_i = en;
    abort_i = ab;
    start_i = st;
    bound_i = bnd_next;
    mode_i = mode_next;
    stp = (ms == 1) && en && !ab;
    prod = 1;
    for (int k = 0; k < NL; k++) begin
      r = b[k] + 1;
      digit = W'((n / prod) % r);
      c[k*W +: W] = digit;
      prod = prod * r;
      w[k] = stp && (((n + 1) % prod) == 0);
    end
    ms2 = 2'(ms);
    exp_q.push_back({ms2, pend_done, (ms == 1), w, c});
    pend_done = w[NL-1];
    if (ms == 1) begin
      if (ab) begin
        ms = 0;
        n = 0;
      end else if (w[NL-1]) begin
        ms = m_mode ? 1 : 2;
        n = 0;
      end else if (stp) begin
        n++;
      end
    end else if (st) begin
      ms = 1;
      n = 0;
      m_mode = mode_next;
      for (int k = 0; k < NL; k++) b[k] = int'(bnd_next[k*W +: W]);
    end else begin
      ms = 0;
    end
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_cnt", 32'(cnt_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    start_i = 1'b0;
    en_i = 1'b0;
    abort_i = 1'b0;
  endtask

  // monitor
  always @(negedge clk) begin
    logic [OW-1:0] obs;
    logic [OW-1:0] e;
    obs = {dbg_state, done_o, busy_o, wrap_o, cnt_o};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("obs", 32'(obs), 32'(e));
      check("last_eq_wrap_top", 32'(last_o), 32'(e[NL*W + NL - 1]));
    end else if (!rst && (wrap_o != '0 || done_o || busy_o)) begin
      check("unexpected_activity", 32'(obs), 32'd0);
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    phase = "idle";
    repeat (2) cycle(1'b1, 1'b1, 1'b0);

    phase = "oneshot_123";
    bnd_next = {4'd3, 4'd2, 4'd1};
    mode_next = 1'b0;
    cycle(1'b0, 1'b0, 1'b1);
    repeat (24) cycle(1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    phase = "en_toggle";
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 48; i++) cycle((i % 2) == 0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    phase = "continuous_001";
    bnd_next = {4'd1, 4'd0, 4'd0};
    mode_next = 1'b1;
    cycle(1'b0, 1'b0, 1'b1);
    repeat (6) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);

    phase = "abort_and_ignored";
    bnd_next = {4'd3, 4'd2, 4'd1};
    mode_next = 1'b0;
    cycle(1'b0, 1'b0, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    bnd_next = {4'd0, 4'd0, 4'd0};
    mode_next = 1'b1;
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, 1'b0);

    phase = "back_to_back";
    bnd_next = {4'd0, 4'd1, 4'd0};
    mode_next = 1'b0;
    cycle(1'b0, 1'b0, 1'b1);
    repeat (2) cycle(1'b1, 1'b0, 1'b0);
    bnd_next = {4'd0, 4'd0, 4'd1};
    cycle(1'b1, 1'b0, 1'b1);
    repeat (2) cycle(1'b1, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);

    phase = "rst_mid_run";
    bnd_next = {4'd3, 4'd2, 4'd1};
    cycle(1'b0, 1'b0, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    reset_mid();
    repeat (3) cycle(1'b1, 1'b0, 1'b0);

    @(posedge clk);
    @(posedge clk);
    phase = "end";
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
